// File: rtl/test_signal_gen_if.sv
// Sample-stream bundle between the synthetic ADC source and its consumers.
// Carries the waveform configuration inward and the strobed samples outward.
interface test_signal_gen_if #(
   parameter int BITS_ADC = 8,
   parameter int BITS_DIV = 16
);
   logic                enable;
   logic [1:0]          waveform;
   logic [BITS_DIV-1:0] divider;
   logic [BITS_ADC-1:0] level_lo;
   logic [BITS_ADC-1:0] level_hi;
   logic [BITS_ADC-1:0] step;
   logic [BITS_ADC-1:0] sample;
   logic                sample_rdy;
   logic                period_start;

   modport master (
      output enable,
      output waveform,
      output divider,
      output level_lo,
      output level_hi,
      output step,
      input  sample,
      input  sample_rdy,
      input  period_start
   );

   modport slave (
      input  enable,
      input  waveform,
      input  divider,
      input  level_lo,
      input  level_hi,
      input  step,
      output sample,
      output sample_rdy,
      output period_start
   );
endinterface

// File: rtl/test_signal_gen.sv
// Synthetic ADC source: ramp/triangle/square/constant sample stream.
// Define TEST_SIGNAL_GEN_DITHER_EN to add saturating LFSR dither.
module test_signal_gen #(
   parameter int BITS_ADC = 8,
   parameter int BITS_DIV = 16
) (
   input logic              clk,
   input logic              rst,
   test_signal_gen_if.slave bus
);
   localparam int W = BITS_ADC + 1;

   typedef enum logic [1:0] {
      ST_UP,
      ST_DOWN,
      ST_LOW,
      ST_HIGH
   } st_e;

   logic [BITS_DIV-1:0] cnt_q, cnt_d;
   logic [BITS_ADC-1:0] acc_q, acc_d;
   logic [BITS_ADC-1:0] hc_q, hc_d;
   logic [BITS_ADC-1:0] sample_q, sample_d;
   st_e                 st_q, st_d, st_init;
   logic                first_q, first_d;
   logic                rdy_q, rdy_d;
   logic                ps_q, ps_d;
   logic [1:0]          wave_q;

   logic                restart, tick, degen;
   logic                is_ramp, is_tri, is_sq, is_const;
   logic [W-1:0]        lo, hi, stp, a, sum, diff, lo_stp, hc_nx;
   logic [BITS_ADC-1:0] out_v, dith_v;

   assign lo     = {1'b0, bus.level_lo};
   assign hi     = {1'b0, bus.level_hi};
   assign stp    = (bus.step == '0) ? W'(1) : {1'b0, bus.step};
   // After any restart the pattern begins at level_lo, whatever acc holds
   assign a      = first_q ? lo : {1'b0, acc_q};
   assign sum    = a + stp;
   assign diff   = a - stp;
   assign lo_stp = lo + stp;
   assign hc_nx  = {1'b0, hc_q} + W'(1);

   assign restart = ~bus.enable | (bus.waveform != wave_q);
   assign tick    = ~restart & (cnt_q >= bus.divider);

   assign is_const = (bus.waveform == 2'd3);
   assign degen    = (hi <= lo) & ~is_const;
   assign is_ramp  = ~degen & (bus.waveform == 2'd0);
   assign is_tri   = ~degen & (bus.waveform == 2'd1);
   assign is_sq    = ~degen & (bus.waveform == 2'd2);
   assign st_init  = (bus.waveform == 2'd1) ? ST_UP : ST_LOW;

   always_comb begin
      out_v = a[BITS_ADC-1:0];
      unique case (1'b1)
         degen:    out_v = bus.level_lo;
         is_sq:    out_v = (st_q == ST_HIGH) ? bus.level_hi : bus.level_lo;
         is_const: out_v = bus.level_hi;
         default:  ;
      endcase
   end

`ifdef TEST_SIGNAL_GEN_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic [W-1:0] dsum;
   logic         fb;

   assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_d = tick ? {lfsr_q[14:0], fb} : lfsr_q;
   assign dsum   = {1'b0, out_v} + W'(lfsr_q[1:0]);
   assign dith_v = dsum[BITS_ADC] ? '1 : dsum[BITS_ADC-1:0];

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign dith_v = out_v;
`endif

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      acc_d    = acc_q;
      hc_d     = hc_q;
      st_d     = st_q;
      first_d  = first_q;
      sample_d = sample_q;
      rdy_d    = tick;
      ps_d     = tick & (first_q | degen);
      if (restart) begin
         cnt_d   = '0;
         acc_d   = bus.level_lo;
         hc_d    = '0;
         st_d    = st_init;
         first_d = 1'b1;
      end else if (tick) begin
         cnt_d    = '0;
         sample_d = dith_v;
         first_d  = 1'b0;
         unique case (1'b1)
            degen: begin
               acc_d   = bus.level_lo;
               hc_d    = '0;
               st_d    = st_init;
               first_d = 1'b1;
            end
            is_ramp: begin
               if (sum > hi) begin
                  acc_d   = bus.level_lo;
                  first_d = 1'b1;
               end else begin
                  acc_d = sum[BITS_ADC-1:0];
               end
            end
            is_tri: begin
               if (st_q == ST_DOWN) begin
                  if (a <= lo_stp) begin
                     acc_d   = bus.level_lo;
                     st_d    = ST_UP;
                     first_d = 1'b1;
                  end else begin
                     acc_d = diff[BITS_ADC-1:0];
                  end
               end else if (sum >= hi) begin
                  acc_d = bus.level_hi;
                  st_d  = ST_DOWN;
               end else begin
                  acc_d = sum[BITS_ADC-1:0];
               end
            end
            is_sq: begin
               if (hc_nx >= stp) begin
                  hc_d = '0;
                  if (st_q == ST_HIGH) begin
                     st_d    = ST_LOW;
                     first_d = 1'b1;
                  end else begin
                     st_d = ST_HIGH;
                  end
               end else begin
                  hc_d = hc_nx[BITS_ADC-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         hc_q     <= '0;
         st_q     <= ST_UP;
         first_q  <= 1'b1;
         wave_q   <= bus.waveform;
         sample_q <= '0;
         rdy_q    <= 1'b0;
         ps_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         hc_q     <= hc_d;
         st_q     <= st_d;
         first_q  <= first_d;
         wave_q   <= bus.waveform;
         sample_q <= sample_d;
         rdy_q    <= rdy_d;
         ps_q     <= ps_d;
      end
   end

   assign bus.sample       = sample_q;
   assign bus.sample_rdy   = rdy_q;
   assign bus.period_start = ps_q;
endmodule

// File: tb/tb_test_signal_gen.sv
// Directed bench for test_signal_gen: waveform sequences, strobe timing,
// restart on enable/waveform change, reset, degenerate range, step=0.
module tb_test_signal_gen;
   localparam int BA = 8;
   localparam int BD = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   test_signal_gen_if #(.BITS_ADC(BA), .BITS_DIV(BD)) bus ();

   test_signal_gen #(.BITS_ADC(BA), .BITS_DIV(BD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cfg(input int wf, input int dv, input int lo,
                      input int hi, input int st);
      bus.waveform = wf[1:0];
      bus.divider  = dv[BD-1:0];
      bus.level_lo = lo[BA-1:0];
      bus.level_hi = hi[BA-1:0];
      bus.step     = st[BA-1:0];
   endtask

   task automatic quiet(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_rdy"}, int'(bus.sample_rdy), 0);
   endtask

   // Next strobe must arrive exactly n cycles on, carrying s and ps
   task automatic smp(input string tag, input int n, input int s,
                      input int ps);
      int k;
      int top;
      k = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (bus.sample_rdy === 1'b1) begin
            k = i;
            break;
         end
      end
      chk({tag, "_lat"}, k, n);
`ifdef TEST_SIGNAL_GEN_DITHER_EN
      top = (s + 3 > 255) ? 255 : s + 3;
      chk({tag, "_smp"},
          int'(int'(bus.sample) >= s && int'(bus.sample) <= top), 1);
`else
      top = s;
      chk({tag, "_smp"}, int'(bus.sample), top);
`endif
      chk({tag, "_ps"}, int'(bus.period_start), ps);
   endtask

   initial begin
      rst        = 1'b1;
      bus.enable = 1'b0;
      cfg(0, 0, 10, 50, 10);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_smp", int'(bus.sample), 0);
      chk("rst_rdy", int'(bus.sample_rdy), 0);
      chk("rst_ps", int'(bus.period_start), 0);

      rst        = 1'b0;
      bus.enable = 1'b1;
      smp("ramp10_a", 1, 10, 1);
      smp("ramp10_b", 1, 20, 0);
      smp("ramp10_c", 1, 30, 0);
      smp("ramp10_d", 1, 40, 0);
      smp("ramp10_e", 1, 50, 0);
      smp("ramp10_f", 1, 10, 1);
      smp("ramp10_g", 1, 20, 0);

      bus.enable = 1'b0;
      bus.step   = 8'd15;
      quiet("en_off_a");
      quiet("en_off_b");
      bus.enable = 1'b1;
      smp("ramp15_a", 1, 10, 1);
      smp("ramp15_b", 1, 25, 0);
      smp("ramp15_c", 1, 40, 0);
      smp("ramp15_d", 1, 10, 1);
      smp("ramp15_e", 1, 25, 0);

      bus.enable = 1'b0;
      cfg(0, 0, 240, 250, 10);
      quiet("en_off_c");
      bus.enable = 1'b1;
      smp("nowrap_a", 1, 240, 1);
      smp("nowrap_b", 1, 250, 0);
      smp("nowrap_c", 1, 240, 1);

      cfg(1, 0, 0, 30, 10);
      quiet("wf_sw");
      smp("tri_a", 1, 0, 1);
      smp("tri_b", 1, 10, 0);
      smp("tri_c", 1, 20, 0);
      smp("tri_d", 1, 30, 0);
      smp("tri_e", 1, 20, 0);
      smp("tri_f", 1, 10, 0);
      smp("tri_g", 1, 0, 1);
      smp("tri_h", 1, 10, 0);

      cfg(2, 3, 5, 200, 2);
      quiet("wf_sq");
      smp("sq_a", 4, 5, 1);
      smp("sq_b", 4, 5, 0);
      smp("sq_c", 4, 200, 0);
      smp("sq_d", 4, 200, 0);
      smp("sq_e", 4, 5, 1);
      smp("sq_f", 4, 5, 0);

      rst = 1'b1;
      cfg(0, 3, 10, 50, 10);
      @(posedge clk);
      #1;
      chk("mid_rst_smp", int'(bus.sample), 0);
      chk("mid_rst_rdy", int'(bus.sample_rdy), 0);
      chk("mid_rst_ps", int'(bus.period_start), 0);
      rst = 1'b0;
      smp("post_rst_a", 4, 10, 1);
      smp("post_rst_b", 4, 20, 0);

      cfg(0, 0, 50, 50, 10);
      smp("degen_a", 1, 50, 1);
      smp("degen_b", 1, 50, 1);

      bus.waveform = 2'd3;
      quiet("wf_const");
      smp("const_a", 1, 50, 1);
      smp("const_b", 1, 50, 0);

      cfg(0, 0, 0, 2, 0);
      quiet("wf_step0");
      smp("step0_a", 1, 0, 1);
      smp("step0_b", 1, 1, 0);
      smp("step0_c", 1, 2, 0);
      smp("step0_d", 1, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/test_signal_gen.md
# test_signal_gen

Synthetic ADC sample source for the buffer controller. It emits a programmable ramp, triangle, square or constant waveform as a sample stream with a one-cycle ready strobe, which is exactly the stream the trigger edge detector and buffer writer consume. It replaces the ADC front end for self-test and for trigger bring-up on hardware without an analog input.

## Interface
- BITS_ADC, 8: sample width.
- BITS_DIV, 16: width of the sample-rate divider.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  1 = generate samples; 0 = idle and restart the pattern.
- waveform  in  2  0 ramp, 1 triangle, 2 square, 3 constant.
- divider  in  BITS_DIV  sample period is divider+1 clocks.
- level_lo  in  BITS_ADC  low level of the waveform.
- level_hi  in  BITS_ADC  high level of the waveform.
- step  in  BITS_ADC  amplitude increment (ramp/triangle), or half-period in samples (square); 0 is treated as 1.
- sample  out  BITS_ADC  current sample; holds its value between strobes.
- sample_rdy  out  1  one-cycle strobe: sample is new.
- period_start  out  1  high with sample_rdy on the first sample of each waveform period.

## Operation
- Prescaler cnt counts 0..divider while enable=1. A tick occurs when cnt==divider; at a tick, cnt returns to 0.
- On a tick, in the same edge: sample <= out_value, sample_rdy <= 1, period_start <= first flag; then the generator advances. Between ticks, sample_rdy=0 and period_start=0.
- Generator state: accumulator acc, direction/phase state (ST_UP/ST_DOWN for triangle, ST_LOW/ST_HIGH for square), half-period counter hc, first flag.
- Arithmetic is done in BITS_ADC+1 bits, so nothing wraps modulo 2^BITS_ADC.
- Ramp: out = acc.
  - If acc+step > level_hi: acc <= level_lo, first <= 1.
  - Else: acc <= acc+step.
- Triangle: out = acc.
  - ST_UP: if acc+step >= level_hi, acc <= level_hi and go to ST_DOWN; else acc += step.
  - ST_DOWN: if acc <= level_lo+step, acc <= level_lo, go to ST_UP, first <= 1; else acc -= step.
- Square:
  - ST_LOW outputs level_lo and ST_HIGH outputs level_hi.
  - hc counts emitted samples; after step samples, switch phase and clear hc.
  - The LOW→HIGH→LOW sequence is one period; first <= 1 on the return to ST_LOW.
- Constant: out = level_hi. first is set only by restart.
- Degenerate range: if level_hi <= level_lo, every tick outputs level_lo with period_start=1, for every waveform except constant.
- Restart condition: any of rst, enable=0, or waveform differing from its registered copy.
  - Restart sets acc <= level_lo, state ST_UP/ST_LOW, hc <= 0, cnt <= 0, first <= 1.
  - sample holds its last value.
- level_lo, level_hi, step and divider are used live. A change takes effect at the next tick and does not cause a restart.

## Timing
- Reset values: sample=0, sample_rdy=0, period_start=0, cnt=0, acc=0, first=1.
- First sample_rdy: the output is high in the cycle after the edge at which cnt==divider. The first strobe comes divider+1 cycles after the first edge at which enable is sampled 1. With divider=0, a strobe occurs every cycle.
- enable falling: no strobe from the next edge on; the pattern restarts on re-enable.
- A waveform change forces a restart on the same edge; no tick is issued that edge.
- Reset mid-operation overrides everything. Outputs are at reset values on the following cycle.

## Configuration
- TEST_SIGNAL_GEN_DITHER_EN defined: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset).
  - The LFSR advances once per tick.
  - sample = min(out + lfsr[1:0], 2^BITS_ADC-1), a saturating add.
  - period_start and state logic are unaffected.
- Undefined: no LFSR; sample = out exactly.

## Test plan
- Ramp, level_lo=10, level_hi=50, step=10, divider=0: sample_rdy every cycle. Samples 10,20,30,40,50,10,…; period_start on each 10.
- Ramp with step=15 (same levels): samples 10,25,40,10,…. Ramp with level_lo=240, level_hi=250, step=10, BITS_ADC=8: samples 240,250,240, with no wrap to 4.
- Triangle, level_lo=0, level_hi=30, step=10: samples 0,10,20,30,20,10,0,10,…; period_start on the 0s only.
- Square, level_lo=5, level_hi=200, step=2, divider=3: strobes every 4 clocks. Samples 5,5,200,200,5,…; period_start on the first 5 of each pair.
- Switch waveform from ramp to triangle mid-period: no strobe that edge. The next sample is level_lo with period_start=1.
- Assert rst (or drop enable) mid-ramp: sample_rdy stays 0. After release, the first sample is level_lo with period_start=1, divider+1 cycles later.
- With TEST_SIGNAL_GEN_DITHER_EN and constant level_hi=255: every sample is 255 (saturation). With level_hi=100: samples stay in 100..103.
